// File: rtl/dioptase_pkg.sv
// Shared types and constants for the dioptase fetch path.
package dioptase_pkg;

  localparam int MEM_RD_LATENCY = 2;
  localparam int INSTR_BYTES    = 4;

  typedef logic [31:0] pc_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    pc_t   pc;
    word_t instr;
  } fetch_entry_t;

  function automatic pc_t align_pc(input pc_t addr);
    return addr & ~pc_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Shift-register return queue: slot 0 is always the head, so head outputs come straight from flops.
// Flush beats push and pop; a push into a full queue without a pop is a credit bug.
module fetch_queue
  import dioptase_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t      slot     [DEPTH];
  fetch_entry_t      slot_nxt [DEPTH];
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     wr_idx;
  logic              do_pop;

  assign do_pop = pop && (count_q != '0);
  assign wr_idx = do_pop ? count_q - CW'(1) : count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_nxt[i] = slot[i];
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) slot_nxt[i] = slot[i + 1];
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CW'(i))) slot_nxt[i] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(push) - CW'(do_pop);
      for (int i = 0; i < DEPTH; i++) slot[i] <= slot_nxt[i];
    end
  end

  assign count = count_q;
  assign head  = slot[0];

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !do_pop && !flush && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one aligned read per cycle while credit allows, tracks it through the
// fixed memory latency and queues returns for decode; redirect squashes everything in flight.
module fetch_unit
  import dioptase_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000,
  parameter int  DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int L  = MEM_RD_LATENCY;
  localparam int CW = $clog2(DEPTH + 1);

  pc_t           pc;
  logic [L-1:0]  trk_vld;
  pc_t           trk_pc [L];
  logic [CW-1:0] q_count;
  fetch_entry_t  head;
  fetch_entry_t  ret;
  logic          issue;
  logic          push;
  logic          pop;

  // Every outstanding fetch already owns a queue slot because the read port cannot stall.
  assign issue = !redirect && ((int'(q_count) + $countones(trk_vld)) < DEPTH);
  assign push  = trk_vld[L-1] && !redirect;
  assign pop   = out_valid && out_ready;
  assign ret   = '{pc: trk_pc[L-1], instr: mem_rdata};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      trk_vld <= '0;
      for (int i = 0; i < L; i++) trk_pc[i] <= '0;
    end else if (redirect) begin
      pc      <= align_pc(redirect_pc);
      trk_vld <= '0;
    end else begin
      trk_vld   <= {trk_vld[L-2:0], issue};
      trk_pc[0] <= pc;
      for (int i = 1; i < L; i++) trk_pc[i] <= trk_pc[i-1];
      if (issue) pc <= pc + pc_t'(INSTR_BYTES);
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (ret),
    .pop       (pop),
    .count     (q_count),
    .head      (head)
  );

  assign mem_raddr = pc;
  assign out_valid = (q_count != '0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a credit/timestamp model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
  );

  function automatic logic [31:0] word_of(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // Memory with a fixed two-cycle read latency.
  logic [31:0] ma1, ma2;
  always @(posedge clk) begin
    ma1 <= mem_raddr;
    ma2 <= ma1;
  end
  assign mem_rdata = word_of(ma2);

  // Model: each fetch not yet consumed holds one credit; it becomes visible 3 cycles after issue.
  typedef struct {
    logic [31:0] pc;
    int          t;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] m_pc;
  bit          m_rst;
  int          cyc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step(input logic r_n, input logic redir, input logic [31:0] rpc, input logic rdy);
    bit ev;
    int n;
    ev = (mq.size() > 0) && (mq[0].t <= cyc);
    check("out_valid", {31'b0, out_valid}, {31'b0, ev});
    check("mem_raddr", mem_raddr, m_pc);
    if (ev) begin
      check("out_pc", out_pc, mq[0].pc);
      check("out_instr", out_instr, word_of(mq[0].pc));
    end
    if (m_rst) begin
      check("reset_out_pc", out_pc, 32'h0);
      check("reset_out_instr", out_instr, 32'h0);
    end
    rst_n       = r_n;
    redirect    = redir;
    redirect_pc = rpc;
    out_ready   = rdy;
    if (!r_n) begin
      mq.delete();
      m_pc  = RESET_PC;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (redir) begin
        mq.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        n = mq.size();
        if (ev && rdy) void'(mq.pop_front());
        if (n < DEPTH) begin
          mq.push_back('{pc: m_pc, t: cyc + 3});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_pc = RESET_PC; m_rst = 1'b1; cyc = 0;
    step(1'b0, 1'b0, 32'h0, 1'b0);

    repeat (25) step(1'b1, 1'b0, 32'h0, 1'b1);               // streaming

    step(1'b0, 1'b0, 32'h0, 1'b0);                            // stall, then drain
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1);

    step(1'b0, 1'b0, 32'h0, 1'b1);                            // redirect at cycle 6 mid-stream
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0203, 1'b1);
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 32'h0000_0400, 1'b1);                    // back-to-back redirects
    step(1'b1, 1'b1, 32'h0000_0802, 1'b0);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);

    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);                    // address wrap
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);

    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);                 // reset with full queue
    step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);

    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0)     step(1'b0, 1'b0, 32'h0, 1'b1);
      else if (r < 8) step(1'b1, 1'b1, $urandom, $urandom_range(0, 1) == 1);
      else            step(1'b1, 1'b0, 32'h0, ((i / 64) % 3 == 2) ? ($urandom_range(0, 3) == 0)
                                                                  : ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the dual-port memory's instruction read port (port 0). Each cycle it drives a word-aligned fetch address, tracks every issued fetch through the memory's fixed 2-cycle read latency, and captures returning instruction words into a small return queue. Instructions leave the queue with their PCs over a valid/ready handshake to decode. Branch redirects squash all in-flight and queued fetches. The memory read port cannot stall, so the unit issues only when queue space is guaranteed for every outstanding fetch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- DEPTH, 4, return-queue entries; legal ≥3, full throughput needs ≥4
- clk  in  1  single clock, all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- mem_raddr  out  32  fetch address to memory read port 0; registered
- mem_rdata  in  32  read data from port 0; valid exactly 2 cycles after the address is presented
- redirect  in  1  squash everything and restart at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  32  PC of head instruction
- out_instr  out  32  head instruction word

## Operation
- State: pc (drives mem_raddr), 2-stage in-flight tracker {valid, pc} aligned to memory latency, return queue of DEPTH {pc, instr}.
- Issue in cycle N when `inflight_count + queue_count < DEPTH` and no redirect: tracker stage 0 gets {1, pc}; pc <= pc + 4 (modulo 2^32, 0xFFFF_FFFC wraps to 0).
- No issue: tracker stage 0 gets valid=0; pc holds; mem_raddr still driven (read is harmless, result discarded).
- Tracker stage 1 valid in cycle N+2: {stage pc, mem_rdata} pushed into queue at end of that cycle. Credit rule guarantees no overflow; overflow is a bug (assertion).
- Pop: out_valid && out_ready at posedge removes head.
- Push and pop same cycle: both occur, count unchanged.
- Redirect in cycle R (highest priority after reset): tracker valids cleared, queue flushed (count 0, out_valid 0 in R+1), pc <= {redirect_pc[31:2],2'b00}, no issue in R; any pop in R is discarded. Returning data in R is dropped.
- Back-to-back redirects: last one wins.
- out_pc/out_instr meaningful only when out_valid; they must not change while out_valid && !out_ready.

## Timing
- Reset (rst_n=0 at posedge): pc=RESET_PC, mem_raddr=RESET_PC, tracker valids 0, queue empty, out_valid=0, out_pc=0, out_instr=0. Reset mid-operation discards everything identically.
- First fetch issued in first cycle after reset release (C0); its instruction is presented with out_valid=1 in C3.
- Issue-to-out latency 3 cycles; redirect in R → first new instruction out_valid in R+4.
- With out_ready held 1 and DEPTH≥4: one instruction per cycle sustained.
- With out_ready held 0: exactly DEPTH instructions accumulate, issue stops, mem_raddr frozen at next unissued PC; resumes one cycle after first pop frees credit.

## Structure
- Shared package dioptase_pkg: MEM_RD_LATENCY=2, INSTR_BYTES=4, pc/word typedefs (32-bit).
- One sub-module: fetch_queue — synchronous FIFO, DEPTH entries of {pc, instr}, push/pop/flush, count output, registered head.
- Top keeps pc, tracker, credit logic.

## Test plan
- Memory word i = 0x1000_0000+i, RESET_PC=0, out_ready=1 → out_valid from cycle 3, out_pc 0,4,8,… one per cycle, out_instr matches word index, no gaps.
- out_ready=0 for 10 cycles after reset → exactly 4 entries held (PC 0..0xC), mem_raddr stalls at 0x10; release → PCs 0x0,0x4,0x8,0xC,0x10 in order, none duplicated or lost.
- redirect to 0x0000_0203 at cycle 6 → no stale PC emitted after R, next out_pc=0x200 at R+4, then 0x204.
- Redirect coincident with valid pop and a memory return → popped/returning entries discarded; next output 0x200 at R+4.
- redirect_pc=0xFFFF_FFF8 → out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n low mid-stream with queue full → next cycle out_valid=0, mem_raddr=RESET_PC; first output RESET_PC 3 cycles after release.
